// File: rtl/serial_paralelo_rx_if.sv
// ============================================================================
// Module      : serial_paralelo_rx_if
// Description : Serial-in / byte-out bundle of one receive lane.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_paralelo_rx_if #(
  parameter int WIDTH = 8
);
  logic             data_in;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             byte_strobe;
  logic             active;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  byte_strobe,
    input  active
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output byte_strobe,
    output active
  );
endinterface

`default_nettype wire

// File: rtl/serial_paralelo_rx.sv
// ============================================================================
// Module      : serial_paralelo_rx
// Description : Comma-aligned serial-to-parallel receiver for one PHY lane.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_paralelo_rx #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] COMMA    = 8'hBC,
  parameter int               BC_COUNT = 4
) (
  input  wire logic           clk_32f,
  input  wire logic           reset,
  serial_paralelo_rx_if.slave bus
);

  localparam int             CW        = $clog2(BC_COUNT + 1);
  localparam logic [CW-1:0]  BC_TARGET = CW'(BC_COUNT);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t           state, state_next;
  // Only WIDTH-1 history bits are needed; the newest bit comes from data_in.
  logic [WIDTH-2:0] sr;
  logic [2:0]       bit_cnt, bit_cnt_next;
  logic [CW-1:0]    bc_cnt, bc_cnt_next, bc_inc;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             valid_reg, valid_next;
  logic             strobe_reg, strobe_next;
  logic [WIDTH-1:0] sym;
  logic             boundary;
  logic             is_comma;

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state      <= ST_HUNT;
      sr         <= '0;
      bit_cnt    <= '0;
      bc_cnt     <= '0;
      data_reg   <= '0;
      valid_reg  <= 1'b0;
      strobe_reg <= 1'b0;
    end else begin
      state      <= state_next;
      sr         <= sym[WIDTH-2:0];
      bit_cnt    <= bit_cnt_next;
      bc_cnt     <= bc_cnt_next;
      data_reg   <= data_next;
      valid_reg  <= valid_next;
      strobe_reg <= strobe_next;
    end
  end

  always_comb begin
    sym          = {sr, bus.data_in};
    is_comma     = (sym == COMMA);
    boundary     = (bit_cnt == 3'd7);
    bc_inc       = (bc_cnt == BC_TARGET) ? bc_cnt : bc_cnt + CW'(1);
    state_next   = state;
    bit_cnt_next = bit_cnt + 3'd1;
    bc_cnt_next  = bc_cnt;
    data_next    = data_reg;
    valid_next   = valid_reg;
    strobe_next  = 1'b0;

    case (state)
      ST_HUNT: begin
        bit_cnt_next = 3'd0;
        valid_next   = 1'b0;
        if (is_comma) begin
          bc_cnt_next = CW'(1);
          state_next  = (BC_COUNT == 1) ? ST_ACTIVE : ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        valid_next = 1'b0;
        if (boundary) begin
          strobe_next = 1'b1;
          if (is_comma) begin
            bc_cnt_next = bc_inc;
            if (bc_inc == BC_TARGET) begin
              state_next = ST_ACTIVE;
            end
          end else begin
            // Misaligned lock (e.g. a lookalike spanning two symbols): rehunt.
            bc_cnt_next  = '0;
            bit_cnt_next = 3'd0;
            state_next   = ST_HUNT;
          end
        end
      end
      ST_ACTIVE: begin
        if (boundary) begin
          strobe_next = 1'b1;
          if (is_comma) begin
            valid_next = 1'b0;
          end else begin
            data_next  = sym;
            valid_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_HUNT;
      end
    endcase
  end

  assign bus.data_out    = data_reg;
  assign bus.valid_out   = valid_reg;
  assign bus.byte_strobe = strobe_reg;
  assign bus.active      = (state == ST_ACTIVE);

endmodule

`default_nettype wire

// File: tb/tb_serial_paralelo_rx.sv
// ============================================================================
// Module      : tb_serial_paralelo_rx
// Description : Directed self-checking bench for serial_paralelo_rx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_paralelo_rx;

  logic clk_32f;
  logic reset;
  int   total_checks;
  int   passed_checks;

  serial_paralelo_rx_if #(.WIDTH(8)) bus0 ();
  serial_paralelo_rx_if #(.WIDTH(8)) bus1 ();

  serial_paralelo_rx #(.WIDTH(8), .COMMA(8'hBC), .BC_COUNT(4)) dut0 (
    .clk_32f (clk_32f),
    .reset   (reset),
    .bus     (bus0)
  );

  serial_paralelo_rx #(.WIDTH(8), .COMMA(8'hBC), .BC_COUNT(1)) dut1 (
    .clk_32f (clk_32f),
    .reset   (reset),
    .bus     (bus1)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  typedef struct {
    logic       do_rst;
    logic [7:0] sym;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_strobe;
    logic       exp_active;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      passed_checks++;
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    bus0.data_in = b;
    bus1.data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] s);
    for (int i = 7; i >= 0; i--) send_bit(s[i]);
  endtask

  task automatic do_reset();
    @(negedge clk_32f);
    reset        = 1'b0;
    bus0.data_in = 1'b0;
    bus1.data_in = 1'b0;
    repeat (2) @(negedge clk_32f);
    reset = 1'b1;
  endtask

  task automatic add(input logic r, input logic [7:0] s, input logic [7:0] d,
                     input logic v, input logic st, input logic a);
    vec_t x;
    x.do_rst = r; x.sym = s; x.exp_data = d;
    x.exp_valid = v; x.exp_strobe = st; x.exp_active = a;
    vecs.push_back(x);
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    reset         = 1'b1;
    bus0.data_in  = 1'b0;
    bus1.data_in  = 1'b0;

    // rst, symbol, data_out, valid_out, byte_strobe, active after last bit
    add(1, 8'hBC, 8'h00, 0, 0, 0);
    add(0, 8'hBC, 8'h00, 0, 1, 0);
    add(0, 8'hBC, 8'h00, 0, 1, 0);
    add(0, 8'hBC, 8'h00, 0, 1, 1);
    add(0, 8'h11, 8'h11, 1, 1, 1);
    add(0, 8'hBC, 8'h11, 0, 1, 1);
    add(0, 8'h22, 8'h22, 1, 1, 1);
    add(1, 8'hBC, 8'h00, 0, 0, 0);
    add(0, 8'hBC, 8'h00, 0, 1, 0);
    add(0, 8'hBC, 8'h00, 0, 1, 0);
    add(0, 8'h37, 8'h00, 0, 1, 0);
    add(0, 8'hBC, 8'h00, 0, 0, 0);
    add(0, 8'hBC, 8'h00, 0, 1, 0);
    add(0, 8'hBC, 8'h00, 0, 1, 0);
    add(0, 8'hBC, 8'h00, 0, 1, 1);

    // Reset state.
    do_reset();
    #1;
    chk("rst_data",   bus0.data_out,           8'h00);
    chk("rst_valid",  {7'd0, bus0.valid_out},   8'h00);
    chk("rst_strobe", {7'd0, bus0.byte_strobe}, 8'h00);
    chk("rst_active", {7'd0, bus0.active},      8'h00);

    // Lock, data/comma passing, failed alignment and relock.
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_rst) do_reset();
      send_byte(vecs[i].sym);
      chk($sformatf("v%0d_data", i),   bus0.data_out,           vecs[i].exp_data);
      chk($sformatf("v%0d_valid", i),  {7'd0, bus0.valid_out},   {7'd0, vecs[i].exp_valid});
      chk($sformatf("v%0d_strobe", i), {7'd0, bus0.byte_strobe}, {7'd0, vecs[i].exp_strobe});
      chk($sformatf("v%0d_active", i), {7'd0, bus0.active},      {7'd0, vecs[i].exp_active});
    end

    // Asynchronous reset mid-symbol while ACTIVE.
    send_byte(8'h66);
    chk("pre_rst_data",  bus0.data_out,         8'h66);
    chk("pre_rst_valid", {7'd0, bus0.valid_out}, 8'h01);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    #2 reset = 1'b0;
    #1;
    chk("async_data",   bus0.data_out,           8'h00);
    chk("async_valid",  {7'd0, bus0.valid_out},   8'h00);
    chk("async_strobe", {7'd0, bus0.byte_strobe}, 8'h00);
    chk("async_active", {7'd0, bus0.active},      8'h00);
    bus0.data_in = 1'b0;
    bus1.data_in = 1'b0;
    @(negedge clk_32f);
    reset = 1'b1;
    repeat (3) send_byte(8'hBC);
    chk("relock3_active", {7'd0, bus0.active}, 8'h00);
    send_byte(8'hBC);
    chk("relock4_active", {7'd0, bus0.active}, 8'h01);

    // Bit offset before the commas, then two data bytes 8 edges apart.
    do_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    repeat (3) send_byte(8'hBC);
    chk("off_active3", {7'd0, bus0.active}, 8'h00);
    send_byte(8'hBC);
    chk("off_active4", {7'd0, bus0.active}, 8'h01);
    send_bit(1'b0);
    chk("off_strobe_drop", {7'd0, bus0.byte_strobe}, 8'h00);
    for (int i = 6; i >= 0; i--) send_bit(((8'h5A >> i) & 8'h01) != 8'h00);
    chk("off_5a_data",   bus0.data_out,           8'h5A);
    chk("off_5a_valid",  {7'd0, bus0.valid_out},   8'h01);
    chk("off_5a_strobe", {7'd0, bus0.byte_strobe}, 8'h01);
    repeat (7) send_bit(1'b1);
    chk("off_hold_data",   bus0.data_out,           8'h5A);
    chk("off_hold_strobe", {7'd0, bus0.byte_strobe}, 8'h00);
    send_bit(1'b1);
    chk("off_ff_data",  bus0.data_out,         8'hFF);
    chk("off_ff_valid", {7'd0, bus0.valid_out}, 8'h01);

    // Single-comma lock variant.
    do_reset();
    send_byte(8'hBC);
    chk("bc1_active", {7'd0, bus1.active},      8'h01);
    chk("bc1_strobe", {7'd0, bus1.byte_strobe}, 8'h00);
    chk("bc1_valid",  {7'd0, bus1.valid_out},   8'h00);
    send_byte(8'hA5);
    chk("bc1_data",    bus1.data_out,           8'hA5);
    chk("bc1_valid2",  {7'd0, bus1.valid_out},   8'h01);
    chk("bc1_strobe2", {7'd0, bus1.byte_strobe}, 8'h01);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

`default_nettype wire
